sleep_timer: RTL and testbench
==============================

// Module: sleep_timer
//
// PURPOSE
//   Parametrised programmable timeout generator with built-in clock divider.
//   A free-running prescaler makes a 50%-duty divided clock and a one-cycle
//   tick. Software/FSM logic loads a timeout in ticks, then starts it in
//   one-shot or periodic mode. The block flags expiry with a timeup pulse
//   and a sticky expired level.
//   It sits between the board clock and the lab state machines, which use it
//   for "wait N seconds" states.
//
// PARAMETERS
//   PRESCALE   50_000_000  input-clock cycles per tick (1 s at 50 MHz); must be >= 2
//   PCNT_W     28          prescaler counter width; must satisfy 2**PCNT_W >= PRESCALE
//   TIMEOUT_W  8           width of load_val and remaining (timeout in ticks)
//
// PORTS
//   inclok     in   1          system clock; all logic on rising edge
//   rst_n      in   1          synchronous reset, active low
//   start      in   1          load load_val, latch periodic, begin timing
//   stop       in   1          abort timing, return to IDLE
//   periodic   in   1          mode at start: 0 = one-shot, 1 = auto-reload
//   load_val   in   TIMEOUT_W  timeout length in ticks
//   outclok    out  1          divided clock: 0 while pcnt < PRESCALE/2, else 1
//   tick       out  1          1-cycle pulse when pcnt == PRESCALE-1
//   busy       out  1          1 while state == RUN
//   timeup     out  1          registered 1-cycle pulse at each expiry
//   expired    out  1          sticky; set at expiry, cleared by start or stop
//   remaining  out  TIMEOUT_W  ticks left in the current period
//
// BEHAVIOUR
//   Reset (rst_n=0 at an edge):
//     state=IDLE, pcnt=0, remaining=0, timeup=0, expired=0,
//     periodic latch=0, reload latch=0.
//     outclok=0 and tick=0 follow from pcnt=0. Reset overrides all inputs,
//     including during RUN.
//   Prescaler:
//     pcnt counts 0..PRESCALE-1 and wraps; it runs in every state.
//     pcnt is forced to 0 on every accepted start, so the outclok phase
//     restarts.
//     outclok and tick are combinational decodes of pcnt.
//   States: IDLE, RUN, DONE.
//   Priority at an edge: reset > stop > start > tick/expiry.
//   stop (any state):
//     -> IDLE, expired=0, no timeup.
//     remaining holds its value; the prescaler keeps running.
//   start (any state, stop=0), load_val != 0:
//     -> RUN; remaining=load_val; latch load_val and periodic; pcnt=0;
//     expired=0.
//     A start in RUN is a restart.
//   start with load_val == 0:
//     timeup=1 for the next cycle, expired=1, state -> DONE, remaining=0.
//   RUN, tick=1, remaining > 1: remaining decrements by 1.
//   RUN, tick=1, remaining == 1 (expiry): timeup=1 next cycle, expired=1.
//     one-shot: -> DONE, remaining=0.
//     periodic: stay in RUN, remaining=latched reload value.
//   Latency: start at edge E gives timeup high for exactly the cycle after
//     edge E + N*PRESCALE, where N = load_val. Periodic pulses repeat every
//     N*PRESCALE cycles.
//   DONE: holds until start or stop. tick keeps pulsing and has no effect.
//   busy = (state == RUN). timeup is never asserted for two consecutive
//     cycles unless PRESCALE*N == 1, which is impossible since PRESCALE >= 2.
//   Inputs are synchronous to inclok; no internal synchroniser.
//
// TESTING  (PRESCALE=4, PCNT_W=3, TIMEOUT_W=4)
//   1. Reset, idle 16 cycles -> outclok 0,0,1,1 repeating; tick every 4th
//      cycle; busy=0, timeup=0, expired=0.
//   2. start, load_val=3, periodic=0 at edge 0 -> remaining 3,2,1 at edges
//      4,8; timeup only after edge 12; then expired=1, busy=0, state DONE.
//   3. start, load_val=2, periodic=1 -> timeup after edges 8, 16, 24;
//      busy stays 1; remaining reloads to 2.
//   4. start, load_val=5, then stop at edge 10 -> IDLE, busy=0, no timeup,
//      remaining=3 held, expired=0.
//   5. start and stop in the same cycle -> IDLE. start, load_val=0 -> one
//      timeup pulse, expired=1, DONE.
//   6. Restart in RUN at edge 6 with load_val=1 -> pcnt=0, timeup after
//      edge 10. rst_n=0 mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sleep_timer_if.sv
// Control/status bundle between a sequencing FSM and the sleep timer.
// The master drives start/stop/mode/length; the timer slave returns clock, tick and expiry status.
interface sleep_timer_if #(
    parameter int TIMEOUT_W = 8
);
    logic                 start;
    logic                 stop;
    logic                 periodic;
    logic [TIMEOUT_W-1:0] load_val;
    logic                 outclok;
    logic                 tick;
    logic                 busy;
    logic                 timeup;
    logic                 expired;
    logic [TIMEOUT_W-1:0] remaining;

    modport master (
        output start, stop, periodic, load_val,
        input  outclok, tick, busy, timeup, expired, remaining
    );

    modport slave (
        input  start, stop, periodic, load_val,
        output outclok, tick, busy, timeup, expired, remaining
    );
endinterface

// File: rtl/sleep_timer.sv
// Programmable tick-based timeout (one-shot or periodic) with free-running prescaler.
// Latency: start at edge E -> timeup high the cycle after edge E + load_val*PRESCALE.
// No backpressure: control inputs act on the next edge, priority reset > stop > start > tick.
module sleep_timer #(
    parameter int PRESCALE  = 50_000_000,
    parameter int PCNT_W    = 28,
    parameter int TIMEOUT_W = 8
) (
    input  logic       inclok,
    input  logic       rst_n,
    sleep_timer_if.slave tmr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PCNT_W-1:0]    PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0]    PCNT_HALF = PCNT_W'(PRESCALE / 2);
    localparam logic [TIMEOUT_W-1:0] ONE       = TIMEOUT_W'(1);

    state_t               state, state_nxt;
    logic [PCNT_W-1:0]    pcnt, pcnt_nxt;
    logic [TIMEOUT_W-1:0] remaining, remaining_nxt;
    logic [TIMEOUT_W-1:0] reload, reload_nxt;
    logic                 periodic_lat, periodic_nxt;
    logic                 timeup, timeup_nxt;
    logic                 expired, expired_nxt;
    logic                 tick;

    assign tick = (pcnt == PCNT_LAST);

    always_ff @(posedge inclok) begin
        if (!rst_n) begin
            state        <= IDLE;
            pcnt         <= '0;
            remaining    <= '0;
            reload       <= '0;
            periodic_lat <= 1'b0;
            timeup       <= 1'b0;
            expired      <= 1'b0;
        end else begin
            state        <= state_nxt;
            pcnt         <= pcnt_nxt;
            remaining    <= remaining_nxt;
            reload       <= reload_nxt;
            periodic_lat <= periodic_nxt;
            timeup       <= timeup_nxt;
            expired      <= expired_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pcnt_nxt      = tick ? '0 : pcnt + PCNT_W'(1);
        remaining_nxt = remaining;
        reload_nxt    = reload;
        periodic_nxt  = periodic_lat;
        timeup_nxt    = 1'b0;
        expired_nxt   = expired;

        if (tmr.stop) begin
            // remaining is deliberately left as-is so software can read where it stopped
            state_nxt   = IDLE;
            expired_nxt = 1'b0;
        end else if (tmr.start) begin
            pcnt_nxt     = '0;
            reload_nxt   = tmr.load_val;
            periodic_nxt = tmr.periodic;
            if (tmr.load_val != '0) begin
                state_nxt     = RUN;
                remaining_nxt = tmr.load_val;
                expired_nxt   = 1'b0;
            end else begin
                state_nxt     = DONE;
                remaining_nxt = '0;
                timeup_nxt    = 1'b1;
                expired_nxt   = 1'b1;
            end
        end else if (state == RUN && tick) begin
            if (remaining > ONE) begin
                remaining_nxt = remaining - ONE;
            end else begin
                timeup_nxt  = 1'b1;
                expired_nxt = 1'b1;
                if (periodic_lat) begin
                    remaining_nxt = reload;
                end else begin
                    state_nxt     = DONE;
                    remaining_nxt = '0;
                end
            end
        end
    end

    assign tmr.outclok   = (pcnt >= PCNT_HALF);
    assign tmr.tick      = tick;
    assign tmr.busy      = (state == RUN);
    assign tmr.timeup    = timeup;
    assign tmr.expired   = expired;
    assign tmr.remaining = remaining;
endmodule

// File: tb/tb_sleep_timer.sv
// Directed bench for sleep_timer with PRESCALE=4, PCNT_W=3, TIMEOUT_W=4.
module tb_sleep_timer;
    logic inclok = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 inclok = ~inclok;

    sleep_timer_if #(.TIMEOUT_W(4)) tif ();

    sleep_timer #(
        .PRESCALE (4),
        .PCNT_W   (3),
        .TIMEOUT_W(4)
    ) dut (
        .inclok(inclok),
        .rst_n (rst_n),
        .tmr   (tif)
    );

    task automatic cyc();
        @(posedge inclok);
        #1;
    endtask

    task automatic clear_inputs();
        tif.start    = 1'b0;
        tif.stop     = 1'b0;
        tif.periodic = 1'b0;
        tif.load_val = 4'd0;
    endtask

    task automatic test_reset();
        logic       exp_oc, exp_tk;
        logic [3:0] oc_pat;
        logic [3:0] tk_pat;
        oc_pat = 4'b1100;
        tk_pat = 4'b1000;
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        total++; if (tif.outclok !== 1'b0) begin bad++; $display("FAIL rst_outclok got=%b want=0", tif.outclok); end
        total++; if (tif.tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", tif.tick); end
        total++; if (tif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", tif.busy); end
        total++; if (tif.timeup !== 1'b0) begin bad++; $display("FAIL rst_timeup got=%b want=0", tif.timeup); end
        total++; if (tif.expired !== 1'b0) begin bad++; $display("FAIL rst_expired got=%b want=0", tif.expired); end
        total++; if (tif.remaining !== 4'd0) begin bad++; $display("FAIL rst_remaining got=%0d want=0", tif.remaining); end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            exp_oc = oc_pat[k % 4];
            exp_tk = tk_pat[k % 4];
            total++; if (tif.outclok !== exp_oc) begin bad++; $display("FAIL idle_outclok k=%0d got=%b want=%b", k, tif.outclok, exp_oc); end
            total++; if (tif.tick !== exp_tk) begin bad++; $display("FAIL idle_tick k=%0d got=%b want=%b", k, tif.tick, exp_tk); end
            total++; if ({tif.busy, tif.timeup, tif.expired} !== 3'b000) begin bad++; $display("FAIL idle_status k=%0d got=%b want=000", k, {tif.busy, tif.timeup, tif.expired}); end
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_rem;
        tif.start = 1'b1; tif.load_val = 4'd3; tif.periodic = 1'b0;
        cyc();
        clear_inputs();
        total++; if (tif.busy !== 1'b1 || tif.remaining !== 4'd3) begin bad++; $display("FAIL os_start busy=%b rem=%0d want busy=1 rem=3", tif.busy, tif.remaining); end
        for (int e = 1; e <= 14; e++) begin
            cyc();
            exp_rem = (e < 4) ? 4'd3 : (e < 8) ? 4'd2 : (e < 12) ? 4'd1 : 4'd0;
            total++; if (tif.remaining !== exp_rem) begin bad++; $display("FAIL os_remaining e=%0d got=%0d want=%0d", e, tif.remaining, exp_rem); end
            total++; if (tif.timeup !== (e == 12)) begin bad++; $display("FAIL os_timeup e=%0d got=%b want=%b", e, tif.timeup, (e == 12)); end
            total++; if (tif.busy !== (e < 12)) begin bad++; $display("FAIL os_busy e=%0d got=%b want=%b", e, tif.busy, (e < 12)); end
            total++; if (tif.expired !== (e >= 12)) begin bad++; $display("FAIL os_expired e=%0d got=%b want=%b", e, tif.expired, (e >= 12)); end
        end
    endtask

    task automatic test_periodic();
        logic [3:0] exp_rem;
        tif.start = 1'b1; tif.load_val = 4'd2; tif.periodic = 1'b1;
        cyc();
        clear_inputs();
        total++; if (tif.expired !== 1'b0) begin bad++; $display("FAIL per_start_expired got=%b want=0", tif.expired); end
        for (int e = 1; e <= 25; e++) begin
            cyc();
            exp_rem = (((e / 4) % 2) == 0) ? 4'd2 : 4'd1;
            total++; if (tif.remaining !== exp_rem) begin bad++; $display("FAIL per_remaining e=%0d got=%0d want=%0d", e, tif.remaining, exp_rem); end
            total++; if (tif.timeup !== (e % 8 == 0)) begin bad++; $display("FAIL per_timeup e=%0d got=%b want=%b", e, tif.timeup, (e % 8 == 0)); end
            total++; if (tif.busy !== 1'b1) begin bad++; $display("FAIL per_busy e=%0d got=%b want=1", e, tif.busy); end
            total++; if (tif.expired !== (e >= 8)) begin bad++; $display("FAIL per_expired e=%0d got=%b want=%b", e, tif.expired, (e >= 8)); end
        end
        tif.stop = 1'b1;
        cyc();
        clear_inputs();
        total++; if (tif.busy !== 1'b0 || tif.expired !== 1'b0) begin bad++; $display("FAIL per_stop busy=%b exp=%b want 0 0", tif.busy, tif.expired); end
    endtask

    task automatic test_stop();
        tif.start = 1'b1; tif.load_val = 4'd5;
        cyc();
        clear_inputs();
        for (int e = 1; e <= 9; e++) cyc();
        total++; if (tif.remaining !== 4'd3) begin bad++; $display("FAIL stop_pre_rem got=%0d want=3", tif.remaining); end
        tif.stop = 1'b1;
        cyc();
        clear_inputs();
        total++; if (tif.busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", tif.busy); end
        total++; if (tif.remaining !== 4'd3) begin bad++; $display("FAIL stop_rem got=%0d want=3", tif.remaining); end
        total++; if (tif.expired !== 1'b0) begin bad++; $display("FAIL stop_expired got=%b want=0", tif.expired); end
        for (int e = 11; e <= 22; e++) begin
            cyc();
            total++; if (tif.timeup !== 1'b0 || tif.remaining !== 4'd3) begin bad++; $display("FAIL stop_hold e=%0d timeup=%b rem=%0d want 0 3", e, tif.timeup, tif.remaining); end
        end
    endtask

    task automatic test_start_stop_zero();
        tif.start = 1'b1; tif.load_val = 4'd4;
        cyc();
        tif.stop = 1'b1; tif.load_val = 4'd7;
        cyc();
        clear_inputs();
        total++; if (tif.busy !== 1'b0) begin bad++; $display("FAIL ss_busy got=%b want=0", tif.busy); end
        total++; if (tif.remaining !== 4'd4) begin bad++; $display("FAIL ss_rem got=%0d want=4", tif.remaining); end
        for (int e = 0; e < 6; e++) cyc();
        total++; if (tif.remaining !== 4'd4 || tif.busy !== 1'b0) begin bad++; $display("FAIL ss_idle rem=%0d busy=%b want 4 0", tif.remaining, tif.busy); end
        tif.start = 1'b1; tif.load_val = 4'd0;
        cyc();
        clear_inputs();
        total++; if (tif.timeup !== 1'b1) begin bad++; $display("FAIL zero_timeup got=%b want=1", tif.timeup); end
        total++; if (tif.expired !== 1'b1) begin bad++; $display("FAIL zero_expired got=%b want=1", tif.expired); end
        total++; if (tif.busy !== 1'b0 || tif.remaining !== 4'd0) begin bad++; $display("FAIL zero_state busy=%b rem=%0d want 0 0", tif.busy, tif.remaining); end
        for (int e = 1; e <= 10; e++) begin
            cyc();
            total++; if (tif.timeup !== 1'b0 || tif.expired !== 1'b1 || tif.busy !== 1'b0) begin bad++; $display("FAIL done_hold e=%0d tu=%b exp=%b busy=%b want 0 1 0", e, tif.timeup, tif.expired, tif.busy); end
        end
    endtask

    task automatic test_restart_and_reset();
        tif.start = 1'b1; tif.load_val = 4'd3;
        cyc();
        clear_inputs();
        for (int e = 1; e <= 5; e++) cyc();
        tif.start = 1'b1; tif.load_val = 4'd1;
        cyc();
        clear_inputs();
        total++; if (tif.remaining !== 4'd1 || tif.busy !== 1'b1) begin bad++; $display("FAIL rs_load rem=%0d busy=%b want 1 1", tif.remaining, tif.busy); end
        total++; if (tif.outclok !== 1'b0 || tif.tick !== 1'b0) begin bad++; $display("FAIL rs_pcnt outclok=%b tick=%b want 0 0", tif.outclok, tif.tick); end
        for (int e = 7; e <= 11; e++) begin
            cyc();
            total++; if (tif.timeup !== (e == 10)) begin bad++; $display("FAIL rs_timeup e=%0d got=%b want=%b", e, tif.timeup, (e == 10)); end
            total++; if (tif.busy !== (e < 10)) begin bad++; $display("FAIL rs_busy e=%0d got=%b want=%b", e, tif.busy, (e < 10)); end
        end
        tif.start = 1'b1; tif.load_val = 4'd1; tif.periodic = 1'b1;
        cyc();
        clear_inputs();
        for (int e = 1; e <= 6; e++) cyc();
        total++; if (tif.busy !== 1'b1 || tif.expired !== 1'b1 || tif.outclok !== 1'b1) begin bad++; $display("FAIL mid_pre busy=%b exp=%b oc=%b want 1 1 1", tif.busy, tif.expired, tif.outclok); end
        rst_n = 1'b0;
        cyc();
        total++; if ({tif.outclok, tif.tick, tif.busy, tif.timeup, tif.expired} !== 5'b0) begin bad++; $display("FAIL mid_rst_flags got=%b want=00000", {tif.outclok, tif.tick, tif.busy, tif.timeup, tif.expired}); end
        total++; if (tif.remaining !== 4'd0) begin bad++; $display("FAIL mid_rst_rem got=%0d want=0", tif.remaining); end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) cyc();
        total++; if (tif.busy !== 1'b0 || tif.timeup !== 1'b0) begin bad++; $display("FAIL post_rst busy=%b tu=%b want 0 0", tif.busy, tif.timeup); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop();
        test_start_stop_zero();
        test_restart_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
